// File: rtl/gty_tx_err_inject.sv
// Per-lane GTY TX error injector: toggle-requested bursts of TXPRBSFORCEERR pulses with programmable gap.
// First pulse 3 edges after a request toggle; a shared abort toggle stops every lane.
module gty_tx_err_inject #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int GAP_WIDTH   = 16
) (
  input  logic                   gty_txusrclk2,
  input  logic                   rst,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic [CHANNELS-1:0]    req_toggle,
  input  logic                   abort_toggle,
  output logic [CHANNELS-1:0]    gty_txprbsforceerr,
  output logic [CHANNELS-1:0]    busy,
  output logic [CHANNELS-1:0]    done_toggle
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [CHANNELS-1:0] req_sync1, req_sync2, req_sync3;
  logic                abort_sync1, abort_sync2, abort_sync3;
  logic [CHANNELS-1:0] req_pulse;
  logic                abort_pulse;

  state_t               state     [CHANNELS];
  logic [COUNT_WIDTH-1:0] remaining [CHANNELS];
  logic [GAP_WIDTH-1:0]   gap_len   [CHANNELS];
  logic [GAP_WIDTH-1:0]   gap_cnt   [CHANNELS];

  // Third stage only serves as the edge-detect reference.
  always_ff @(posedge gty_txusrclk2) begin
    if (rst) begin
      req_sync1   <= '0;
      req_sync2   <= '0;
      req_sync3   <= '0;
      abort_sync1 <= 1'b0;
      abort_sync2 <= 1'b0;
      abort_sync3 <= 1'b0;
    end else begin
      req_sync1   <= req_toggle;
      req_sync2   <= req_sync1;
      req_sync3   <= req_sync2;
      abort_sync1 <= abort_toggle;
      abort_sync2 <= abort_sync1;
      abort_sync3 <= abort_sync2;
    end
  end

  assign req_pulse   = req_sync2 ^ req_sync3;
  assign abort_pulse = abort_sync2 ^ abort_sync3;

  always_ff @(posedge gty_txusrclk2) begin
    if (rst) begin
      gty_txprbsforceerr <= '0;
      busy               <= '0;
      done_toggle        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]     <= IDLE;
        remaining[i] <= '0;
        gap_len[i]   <= '0;
        gap_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (abort_pulse) begin
          // Abort beats any request arriving on the same edge.
          state[i]              <= IDLE;
          gty_txprbsforceerr[i] <= 1'b0;
          busy[i]               <= 1'b0;
          if (state[i] != IDLE)
            done_toggle[i] <= ~done_toggle[i];
        end else begin
          case (state[i])
            IDLE: begin
              if (req_pulse[i]) begin
                if (cfg_count != '0) begin
                  remaining[i]          <= cfg_count;
                  gap_len[i]            <= cfg_gap;
                  state[i]              <= PULSE;
                  gty_txprbsforceerr[i] <= 1'b1;
                  busy[i]               <= 1'b1;
                end else begin
                  done_toggle[i] <= ~done_toggle[i];
                end
              end
            end
            PULSE: begin
              remaining[i] <= remaining[i] - COUNT_WIDTH'(1);
              if (remaining[i] == COUNT_WIDTH'(1)) begin
                state[i]              <= IDLE;
                gty_txprbsforceerr[i] <= 1'b0;
                busy[i]               <= 1'b0;
                done_toggle[i]        <= ~done_toggle[i];
              end else if (gap_len[i] == '0) begin
                gty_txprbsforceerr[i] <= 1'b1;
              end else begin
                state[i]              <= GAP;
                gap_cnt[i]            <= gap_len[i];
                gty_txprbsforceerr[i] <= 1'b0;
              end
            end
            GAP: begin
              if (gap_cnt[i] == GAP_WIDTH'(1)) begin
                state[i]              <= PULSE;
                gty_txprbsforceerr[i] <= 1'b1;
              end else begin
                gap_cnt[i] <= gap_cnt[i] - GAP_WIDTH'(1);
              end
            end
            default: begin
              state[i]              <= IDLE;
              gty_txprbsforceerr[i] <= 1'b0;
              busy[i]               <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gty_tx_err_inject.sv
// Bench for gty_tx_err_inject: burst schedules are predicted as cycle lists from count/gap arithmetic
// and a negedge monitor compares every lane's outputs against them.
module tb_gty_tx_err_inject;
  localparam int CH = 4;

  typedef struct {int s; int e;} span_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_count = '0;
  logic [15:0]   cfg_gap = '0;
  logic [CH-1:0] req_toggle = '0;
  logic          abort_toggle = 1'b0;
  logic [CH-1:0] forceerr, busy, done_toggle;

  gty_tx_err_inject #(.CHANNELS(CH), .COUNT_WIDTH(16), .GAP_WIDTH(16)) dut (
    .gty_txusrclk2      (clk),
    .rst                (rst),
    .cfg_count          (cfg_count),
    .cfg_gap            (cfg_gap),
    .req_toggle         (req_toggle),
    .abort_toggle       (abort_toggle),
    .gty_txprbsforceerr (forceerr),
    .busy               (busy),
    .done_toggle        (done_toggle)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Expected-event queues, indexed by the sample cycle (edge count) they appear in.
  int    pq [CH][$];
  int    dq [CH][$];
  span_t bq [CH][$];
  int    lane_s [CH];
  int    lane_e [CH];
  int    abort_edge = -1;
  bit    exp_done [CH];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input int l, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s[%0d] cyc %0d: got %b want %b", nm, l, cyc, got, want);
    end
  endtask

  task automatic do_abort(input int a);
    abort_edge = a;
    for (int l = 0; l < CH; l++) begin
      if (lane_s[l] < a && a <= lane_e[l]) begin
        while (pq[l].size() > 0 && pq[l][$] >= a) void'(pq[l].pop_back());
        while (dq[l].size() > 0 && dq[l][$] >= a) void'(dq[l].pop_back());
        dq[l].push_back(a);
        for (int i = 0; i < bq[l].size(); i++) begin
          span_t t = bq[l][i];
          if (t.e > a) begin
            t.e = a;
            bq[l][i] = t;
          end
        end
        lane_e[l] = a;
      end
    end
  endtask

  task automatic do_req(input int l, input int e, input int n, input int g);
    int end_c;
    span_t t;
    if (e == abort_edge) return;
    if (lane_s[l] < e && e <= lane_e[l]) return;
    if (n == 0) begin
      dq[l].push_back(e);
      return;
    end
    end_c = e + n + (n - 1) * g;
    for (int j = 0; j < n; j++) pq[l].push_back(e + j * (g + 1));
    dq[l].push_back(end_c);
    t.s = e;
    t.e = end_c;
    bq[l].push_back(t);
    lane_s[l] = e;
    lane_e[l] = end_c;
  endtask

  // Called just after a falling edge; the request is seen by the FSM on the 3rd rising edge.
  task automatic issue(input logic [CH-1:0] lanes, input bit ab, input int n, input int g);
    int k;
    k = cyc;
    cfg_count = 16'(n);
    cfg_gap   = 16'(g);
    if (ab) begin
      abort_toggle = ~abort_toggle;
      do_abort(k + 3);
    end
    for (int l = 0; l < CH; l++) begin
      if (lanes[l]) begin
        req_toggle[l] = ~req_toggle[l];
        do_req(l, k + 3, n, g);
      end
    end
  endtask

  task automatic do_reset(input int ncyc);
    int k;
    k = cyc;
    rst = 1'b1;
    for (int l = 0; l < CH; l++) begin
      while (pq[l].size() > 0 && pq[l][$] > k) void'(pq[l].pop_back());
      while (dq[l].size() > 0 && dq[l][$] > k) void'(dq[l].pop_back());
      while (bq[l].size() > 0 && bq[l][$].s > k) void'(bq[l].pop_back());
      for (int i = 0; i < bq[l].size(); i++) begin
        span_t t = bq[l][i];
        if (t.e > k + 1) begin
          t.e = k + 1;
          bq[l][i] = t;
        end
      end
      lane_s[l] = -10;
      lane_e[l] = -10;
    end
    abort_edge = -1;
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    k = cyc;
    // Synchronizers restart from 0, so any input bit left high reads as one fresh edge.
    if (abort_toggle) do_abort(k + 3);
    for (int l = 0; l < CH; l++)
      if (req_toggle[l]) do_req(l, k + 3, int'(cfg_count), int'(cfg_gap));
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int l = 0; l < CH; l++) begin
        bit ef, eb;
        if (rst_seen) exp_done[l] = 1'b0;
        ef = 1'b0;
        if (pq[l].size() > 0 && pq[l][0] == cyc) begin
          ef = 1'b1;
          void'(pq[l].pop_front());
        end
        if (dq[l].size() > 0 && dq[l][0] == cyc) begin
          exp_done[l] = ~exp_done[l];
          void'(dq[l].pop_front());
        end
        while (bq[l].size() > 0 && bq[l][0].e <= cyc) void'(bq[l].pop_front());
        eb = (bq[l].size() > 0 && bq[l][0].s <= cyc);
        chk("forceerr", l, forceerr[l], ef);
        chk("busy", l, busy[l], eb);
        chk("done_toggle", l, done_toggle[l], exp_done[l]);
      end
    end
  end

  initial begin
    int k0;
    for (int l = 0; l < CH; l++) begin
      lane_s[l]   = -10;
      lane_e[l]   = -10;
      exp_done[l] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Gapped burst 1,0,0,1,0,0,1 on lane 0.
    issue(4'b0001, 1'b0, 3, 2);
    repeat (14) @(negedge clk);
    // Continuous burst on lane 1.
    issue(4'b0010, 1'b0, 4, 0);
    repeat (10) @(negedge clk);
    // Zero-length request on lane 2.
    issue(4'b0100, 1'b0, 0, 0);
    repeat (8) @(negedge clk);

    // Long burst aborted in its 2nd gap; a re-request and a cfg change mid-burst must not matter.
    k0 = cyc;
    issue(4'b0001, 1'b0, 100, 5);
    repeat (4) @(negedge clk);
    issue(4'b0001, 1'b0, 100, 5);
    @(negedge clk);
    cfg_count = 16'd1;
    cfg_gap   = 16'd0;
    while (cyc < k0 + 8) @(negedge clk);
    issue(4'b0000, 1'b1, 1, 0);
    repeat (12) @(negedge clk);

    // All lanes on the same edge.
    issue(4'b1111, 1'b0, 2, 1);
    repeat (8) @(negedge clk);

    // Reset mid-burst, then a fresh full burst.
    issue(4'b0011, 1'b0, 5, 1);
    repeat (5) @(negedge clk);
    do_reset(2);
    repeat (6) @(negedge clk);
    issue(4'b0100, 1'b0, 3, 1);
    repeat (10) @(negedge clk);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        issue(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 6), $urandom_range(0, 3));
      end
      repeat ($urandom_range(3, 20)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    for (int l = 0; l < CH; l++) begin
      n_cmp++;
      if (pq[l].size() != 0 || dq[l].size() != 0) begin
        n_bad++;
        $display("FAIL pending[%0d]: got %0d pulses %0d flips unseen, want 0", l, pq[l].size(), dq[l].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
